// File: rtl/compare_condition_stage.sv
// compare_condition_stage: two-stage pipelined compare with condition evaluation.
//   S1 registers the operand pair, condition code and signedness, and drives an internal
//   fast_comparator. S2 registers the corrected above/below/equal flags and the taken bit.
//   Both stages use a valid/ready handshake with backpressure from downstream.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   in_valid_i     - operand pair and condition present
//   in_ready_o     - stage can accept this cycle
//   in_a_i, in_b_i - operands A and B
//   in_cond_i      - condition code: EQ, NE, GT, LT, GE, LE, ALWAYS, NEVER (000..111)
//   in_signed_i    - 1 = two's-complement compare, 0 = unsigned
//   out_valid_o    - result present
//   out_ready_i    - downstream accepts result
//   out_above_o    - A > B under the selected signedness
//   out_below_o    - A < B under the selected signedness
//   out_equal_o    - A == B
//   out_taken_o    - condition evaluated true
//
// fast_comparator: purely combinational unsigned magnitude comparator.
// Ports:
//   a_i, b_i  - operands
//   above_o   - a_i > b_i (unsigned)
//   below_o   - a_i < b_i (unsigned)

module fast_comparator #(
  parameter int unsigned WordWidth = 8
) (
  input  logic [WordWidth-1:0] a_i,
  input  logic [WordWidth-1:0] b_i,
  output logic                 above_o,
  output logic                 below_o
);

  assign above_o = (a_i > b_i);
  assign below_o = (a_i < b_i);

endmodule

module compare_condition_stage #(
  parameter int unsigned word_width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [word_width-1:0] in_a_i,
  input  logic [word_width-1:0] in_b_i,
  input  logic [2:0]            in_cond_i,
  input  logic                  in_signed_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_above_o,
  output logic                  out_below_o,
  output logic                  out_equal_o,
  output logic                  out_taken_o
);

  localparam int unsigned Msb = word_width - 1;

  // S1: operand stage
  logic                  s1_valid_q;
  logic [word_width-1:0] s1_a_q, s1_b_q;
  logic [2:0]            s1_cond_q;
  logic                  s1_signed_q;

  // S2: result stage
  logic s2_valid_q;
  logic s2_above_q, s2_below_q, s2_equal_q, s2_taken_q;

  logic in_fire, s2_adv;
  logic c_above, c_below;
  logic above_d, below_d, equal_d, taken_d;

  assign s2_adv     = s1_valid_q & (~s2_valid_q | out_ready_i);
  assign in_ready_o = ~s1_valid_q | s2_adv;
  assign in_fire    = in_valid_i & in_ready_o;

  fast_comparator #(
    .WordWidth (word_width)
  ) u_fast_comparator (
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .above_o (c_above),
    .below_o (c_below)
  );

  always_comb begin
    above_d = c_above;
    below_d = c_below;
    // With differing sign bits in signed mode the negative operand is the smaller one.
    if (s1_signed_q && (s1_a_q[Msb] != s1_b_q[Msb])) begin
      above_d = s1_b_q[Msb];
      below_d = s1_a_q[Msb];
    end
    equal_d = ~above_d & ~below_d;

    taken_d = 1'b0;
    unique case (s1_cond_q)
      3'b000:  taken_d = equal_d;
      3'b001:  taken_d = ~equal_d;
      3'b010:  taken_d = above_d;
      3'b011:  taken_d = below_d;
      3'b100:  taken_d = above_d | equal_d;
      3'b101:  taken_d = below_d | equal_d;
      3'b110:  taken_d = 1'b1;
      3'b111:  taken_d = 1'b0;
      default: taken_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_cond_q   <= 3'b000;
      s1_signed_q <= 1'b0;
    end else begin
      s1_valid_q <= in_fire | (s1_valid_q & ~s2_adv);
      if (in_fire) begin
        s1_a_q      <= in_a_i;
        s1_b_q      <= in_b_i;
        s1_cond_q   <= in_cond_i;
        s1_signed_q <= in_signed_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_above_q <= 1'b0;
      s2_below_q <= 1'b0;
      s2_equal_q <= 1'b0;
      s2_taken_q <= 1'b0;
    end else begin
      s2_valid_q <= s2_adv | (s2_valid_q & ~out_ready_i);
      if (s2_adv) begin
        s2_above_q <= above_d;
        s2_below_q <= below_d;
        s2_equal_q <= equal_d;
        s2_taken_q <= taken_d;
      end
    end
  end

  // Flags are forced low whenever no result is presented.
  assign out_valid_o = s2_valid_q;
  assign out_above_o = s2_valid_q & s2_above_q;
  assign out_below_o = s2_valid_q & s2_below_q;
  assign out_equal_o = s2_valid_q & s2_equal_q;
  assign out_taken_o = s2_valid_q & s2_taken_q;

endmodule

// File: doc/compare_condition_stage.md
Name: compare_condition_stage

Overview:
- Pipelined compare stage wrapped around fast_comparator.
- Accepts operand pairs with a condition code over a valid/ready handshake, registers them, and feeds the registered operands to an internal fast_comparator instance.
- Consumes the comparator's above/below outputs and applies a signed-mode correction.
- Evaluates the condition and presents registered flags plus a taken bit downstream (branch unit / flag register) with backpressure.

Parameters:
- word_width, 8, operand width in bits; legal range ≥ 2; passed unchanged to fast_comparator.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and condition present.
- in_ready  output  1  stage can accept this cycle.
- in_a  input  word_width  operand A.
- in_b  input  word_width  operand B.
- in_cond  input  3  condition code (encoding below).
- in_signed  input  1  1 = two's-complement compare; 0 = unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_above  output  1  A > B under the selected signedness.
- out_below  output  1  A < B under the selected signedness.
- out_equal  output  1  A == B.
- out_taken  output  1  condition evaluated true.

Behaviour:
- Condition codes: 000 EQ, 001 NE, 010 GT, 011 LT, 100 GE, 101 LE, 110 ALWAYS (1), 111 NEVER (0).
- Pipeline structure: two registered stages, S1 (operands) and S2 (result), each with its own valid bit.
  - S1 holds A, B, cond and signed. The fast_comparator inputs are driven only from the S1 registers.
  - S2 holds above, below, equal and taken.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - s2_adv = S1 valid & (!S2 valid | out_ready).
  - in_ready = !S1 valid | s2_adv, computed combinationally.
  - No combinational path from in_valid to out_valid.
  - An out_ready-to-in_ready combinational path is permitted.
- Latency and throughput:
  - An accepted transaction appears on out_valid exactly 2 cycles after acceptance when unstalled.
  - Sustained throughput is 1 per cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, all out_* signals hold stable and S2 does not change. S1 still accepts one entry if it is empty; the stage holds at most 2 in-flight transactions.
- Simultaneous events: in the same cycle, out_fire empties S2, s2_adv refills S2 from S1, and in_fire refills S1. No loss or duplication is allowed.
- Signed correction, applied at S1→S2 from the comparator outputs c_above and c_below; msb = word_width-1:
  - Unsigned mode, or signed mode with A[msb]==B[msb]: above=c_above, below=c_below.
  - Signed mode with A[msb]!=B[msb]: above=B[msb], below=A[msb].
  - equal = !above & !below.
  - above and below are never both 1.
- Taken: GE = above|equal; LE = below|equal; the remaining codes follow the table.
- Reset:
  - Asynchronous assertion clears both valid bits immediately.
  - out_valid=0, out_above=0, out_below=0, out_equal=0, out_taken=0; in_ready=1 after reset.
  - Data registers are don't-care, but all outputs are gated to 0 while out_valid=0.
  - Reset mid-operation discards all in-flight transactions.
  - First acceptance is possible in the first cycle after deassertion.
- Outputs are stable and registered; no output glitches from in_* inputs.

Test Plan:
- Reset/idle: after rst_n release, out_valid=0, all flags 0, in_ready=1; no output appears without in_valid.
- Unsigned, word_width=8: A=200, B=100, cond=GT, signed=0 → 2 cycles later out_valid=1, above=1, below=0, equal=0, taken=1. A=100, B=100, cond=LE → equal=1, taken=1.
- Signed crossing: A=8'hFF (-1), B=8'h01, signed=1, cond=LT → below=1, taken=1. The same operands with signed=0 → above=1, taken=0.
- All eight condition codes for A=5, B=9, unsigned → taken = 0,1,0,1,0,1,1,0 for codes 000..111.
- Backpressure: stream 4 transactions back-to-back with out_ready=0 → in_ready drops after 2 are accepted and outputs hold the first result. Then release out_ready → results emerge in order, one per cycle, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 while 2 transactions are in flight → out_valid falls immediately without a clock edge; after release, no stale result is emitted.
